// File: rtl/frame_buffer_access_scheduler.sv
// Frame buffer access scheduler: writes each accepted pixel into a 3-row
// buffer and, once a full 3x3 window exists, reads the oldest row back.
module frame_buffer_access_scheduler #(
  parameter int P_FRAME_COLUMNS     = 640,
  parameter int P_FRAME_ROWS        = 480,
  parameter int P_PIXEL_DEPTH       = 4,
  parameter int P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
  parameter int P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS)
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET,
  input  logic                           I_PIXEL_STROBE,
  input  logic                           I_DATA_VALID,
  input  logic [P_PIXEL_DEPTH-1:0]       I_PIXEL,
  output logic [P_FRAME_COLUMN_BITS-1:0] O_BUF_COLUMN,
  output logic [1:0]                     O_BUF_ROW,
  output logic [P_PIXEL_DEPTH-1:0]       O_BUF_PIXEL,
  output logic                           O_BUF_WRITE_ENABLE,
  output logic                           O_BUF_READ_ENABLE,
  output logic [P_FRAME_COLUMN_BITS-1:0] O_MATRIX_COLUMN,
  output logic [P_FRAME_ROW_BITS-1:0]    O_MATRIX_ROW,
  output logic                           O_MATRIX_READY,
  output logic                           O_OVERRUN
);

  localparam int CB = P_FRAME_COLUMN_BITS;
  localparam int RB = P_FRAME_ROW_BITS;

  localparam logic [CB-1:0] LAST_COL = CB'(P_FRAME_COLUMNS - 1);
  localparam logic [RB-1:0] LAST_ROW = RB'(P_FRAME_ROWS - 1);
  localparam logic [CB-1:0] ONE_C    = CB'(1);
  localparam logic [CB-1:0] TWO_C    = CB'(2);
  localparam logic [RB-1:0] ONE_R    = RB'(1);
  localparam logic [RB-1:0] TWO_R    = RB'(2);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    WAIT
  } state_t;

  state_t                   state;
  logic [CB-1:0]            col;
  logic [RB-1:0]            row_cnt;
  logic [1:0]               wr_row;
  logic                     pend_valid;
  logic [P_PIXEL_DEPTH-1:0] pend_pixel;

  logic       accept;
  logic       do_read;
  logic [1:0] old_row;

  assign accept  = I_PIXEL_STROBE & I_DATA_VALID;
  assign do_read = (row_cnt >= TWO_R) && (col >= TWO_C);
  assign old_row = (wr_row == 2'd2) ? 2'd0 : wr_row + 2'd1;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state              <= IDLE;
      col                <= '0;
      row_cnt            <= '0;
      wr_row             <= '0;
      pend_valid         <= 1'b0;
      pend_pixel         <= '0;
      O_BUF_COLUMN       <= '0;
      O_BUF_ROW          <= '0;
      O_BUF_PIXEL        <= '0;
      O_BUF_WRITE_ENABLE <= 1'b0;
      O_BUF_READ_ENABLE  <= 1'b0;
      O_MATRIX_COLUMN    <= '0;
      O_MATRIX_ROW       <= '0;
      O_MATRIX_READY     <= 1'b0;
      O_OVERRUN          <= 1'b0;
    end else begin
      O_BUF_WRITE_ENABLE <= 1'b0;
      O_BUF_READ_ENABLE  <= 1'b0;
      O_MATRIX_READY     <= 1'b0;
      unique case (state)
        IDLE: begin
          // A queued pixel goes first; a new one arriving now finds no room.
          if (pend_valid) begin
            state              <= WRITE;
            O_BUF_WRITE_ENABLE <= 1'b1;
            O_BUF_COLUMN       <= col;
            O_BUF_ROW          <= wr_row;
            O_BUF_PIXEL        <= pend_pixel;
            pend_valid         <= 1'b0;
            if (accept) O_OVERRUN <= 1'b1;
          end else if (accept) begin
            state              <= WRITE;
            O_BUF_WRITE_ENABLE <= 1'b1;
            O_BUF_COLUMN       <= col;
            O_BUF_ROW          <= wr_row;
            O_BUF_PIXEL        <= I_PIXEL;
          end
        end
        WRITE: begin
          if (do_read) begin
            state             <= READ;
            O_BUF_READ_ENABLE <= 1'b1;
            O_BUF_COLUMN      <= col - TWO_C;
            O_BUF_ROW         <= old_row;
            O_MATRIX_COLUMN   <= col - TWO_C;
            O_MATRIX_ROW      <= row_cnt - TWO_R;
          end else begin
            state <= IDLE;
          end
          if (col == LAST_COL) begin
            col <= '0;
            if (row_cnt == LAST_ROW) begin
              row_cnt <= '0;
              wr_row  <= '0;
            end else begin
              row_cnt <= row_cnt + ONE_R;
              wr_row  <= old_row;
            end
          end else begin
            col <= col + ONE_C;
          end
        end
        READ: begin
          state          <= WAIT;
          O_MATRIX_READY <= 1'b1;
        end
        WAIT: begin
          state <= IDLE;
        end
      endcase
      if (accept && state != IDLE) begin
        if (!pend_valid) begin
          pend_valid <= 1'b1;
          pend_pixel <= I_PIXEL;
        end else begin
          O_OVERRUN <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_access_scheduler.sv
// Directed bench for frame_buffer_access_scheduler: 640 columns, 6-row frame
// so a full frame wrap fits in a short run.
module tb_frame_buffer_access_scheduler;

  localparam int COLS = 640;
  localparam int ROWS = 6;
  localparam int PD   = 4;
  localparam int CB   = $clog2(COLS);
  localparam int RB   = $clog2(ROWS);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stb = 1'b0;
  logic          dv  = 1'b0;
  logic [PD-1:0] pix = '0;
  logic [CB-1:0] buf_col;
  logic [1:0]    buf_row;
  logic [PD-1:0] buf_pixel;
  logic          we;
  logic          re;
  logic [CB-1:0] m_col;
  logic [RB-1:0] m_row;
  logic          ready;
  logic          overrun;

  frame_buffer_access_scheduler #(
    .P_FRAME_COLUMNS(COLS),
    .P_FRAME_ROWS   (ROWS),
    .P_PIXEL_DEPTH  (PD)
  ) dut (
    .I_CLK             (clk),
    .I_RESET           (rst),
    .I_PIXEL_STROBE    (stb),
    .I_DATA_VALID      (dv),
    .I_PIXEL           (pix),
    .O_BUF_COLUMN      (buf_col),
    .O_BUF_ROW         (buf_row),
    .O_BUF_PIXEL       (buf_pixel),
    .O_BUF_WRITE_ENABLE(we),
    .O_BUF_READ_ENABLE (re),
    .O_MATRIX_COLUMN   (m_col),
    .O_MATRIX_ROW      (m_row),
    .O_MATRIX_READY    (ready),
    .O_OVERRUN         (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int rdy_cnt = 0;
  int both_cnt = 0;
  logic [CB-1:0] last_wcol = '0;
  logic [1:0]    last_wrow = '0;
  logic [PD-1:0] last_wpix = '0;

  always @(negedge clk) begin
    if (we) begin
      wr_cnt++;
      last_wcol = buf_col;
      last_wrow = buf_row;
      last_wpix = buf_pixel;
    end
    if (re) rd_cnt++;
    if (ready) rdy_cnt++;
    if (we && re) both_cnt++;
  end

  task automatic send(input logic v, input logic [PD-1:0] p);
    @(negedge clk);
    stb = 1'b1; dv = v; pix = p;
    @(negedge clk);
    stb = 1'b0; dv = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    int w0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({we, re, ready, overrun, buf_col, buf_row, buf_pixel, m_col, m_row} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b re=%b rdy=%b ovr=%b col=%0d row=%0d pix=%0d mcol=%0d mrow=%0d, required all 0",
               we, re, ready, overrun, buf_col, buf_row, buf_pixel, m_col, m_row);
    end
    w0 = wr_cnt;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (wr_cnt !== w0) begin
      errors++;
      $display("FAIL reset_idle: writes=%0d required %0d", wr_cnt, w0);
    end
  endtask

  task automatic test_qualification();
    int w0;
    do_reset();
    w0 = wr_cnt;
    send(1'b1, 4'h3);
    checks++;
    if (wr_cnt !== w0 + 1 || last_wcol !== '0 || last_wpix !== 4'h3) begin
      errors++;
      $display("FAIL qual_first: writes=%0d col=%0d pix=%0d required %0d/0/3", wr_cnt - w0, last_wcol, last_wpix, 1);
    end
    send(1'b0, 4'h9);
    checks++;
    if (wr_cnt !== w0 + 1) begin
      errors++;
      $display("FAIL qual_dv0: writes=%0d required 1", wr_cnt - w0);
    end
    send(1'b1, 4'h5);
    checks++;
    if (last_wcol !== CB'(1) || last_wpix !== 4'h5 || wr_cnt !== w0 + 2) begin
      errors++;
      $display("FAIL qual_col: col=%0d pix=%0d writes=%0d required 1/5/2", last_wcol, last_wpix, wr_cnt - w0);
    end
  endtask

  task automatic test_overrun();
    int w0;
    do_reset();
    w0 = wr_cnt;
    @(negedge clk);
    stb = 1'b1; dv = 1'b1; pix = 4'hA;
    @(negedge clk);
    pix = 4'hB;
    @(negedge clk);
    pix = 4'hC;
    @(negedge clk);
    stb = 1'b0; dv = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (wr_cnt !== w0 + 2 || last_wpix !== 4'hB || last_wcol !== CB'(1)) begin
      errors++;
      $display("FAIL overrun_writes: writes=%0d pix=%0h col=%0d required 2/b/1", wr_cnt - w0, last_wpix, last_wcol);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: overrun=%b required 1", overrun);
    end
    send(1'b1, 4'h1);
    repeat (20) @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: overrun=%b required 1", overrun);
    end
    do_reset();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: overrun=%b required 0", overrun);
    end
  endtask

  task automatic test_first_row();
    int w0, r0, y0;
    do_reset();
    w0 = wr_cnt; r0 = rd_cnt; y0 = rdy_cnt;
    for (int c = 0; c < COLS; c++) begin
      send(1'b1, PD'(c));
      checks++;
      if (last_wcol !== CB'(c) || last_wrow !== 2'd0 || last_wpix !== PD'(c)) begin
        errors++;
        $display("FAIL row0_write: col=%0d row=%0d pix=%0d required %0d/0/%0d", last_wcol, last_wrow, last_wpix, c, c % 16);
      end
    end
    checks++;
    if (wr_cnt - w0 !== COLS || rd_cnt !== r0 || rdy_cnt !== y0) begin
      errors++;
      $display("FAIL row0_counts: writes=%0d reads=%0d ready=%0d required 640/0/0", wr_cnt - w0, rd_cnt - r0, rdy_cnt - y0);
    end
  endtask

  task automatic test_row2();
    for (int c = 0; c < COLS; c++) send(1'b1, PD'(c));
    checks++;
    if (last_wrow !== 2'd1 || last_wcol !== CB'(COLS - 1)) begin
      errors++;
      $display("FAIL row1_end: col=%0d row=%0d required 639/1", last_wcol, last_wrow);
    end
    for (int c = 0; c < 5; c++) send(1'b1, PD'(c));
    @(negedge clk);
    stb = 1'b1; dv = 1'b1; pix = 4'hA;
    @(negedge clk);
    stb = 1'b0; dv = 1'b0;
    checks++;
    if (!(we === 1'b1 && re === 1'b0 && buf_col === CB'(5) && buf_row === 2'd2 && buf_pixel === 4'hA)) begin
      errors++;
      $display("FAIL row2_write: we=%b re=%b col=%0d row=%0d pix=%0h required 1/0/5/2/a", we, re, buf_col, buf_row, buf_pixel);
    end
    @(negedge clk);
    checks++;
    if (!(re === 1'b1 && we === 1'b0 && buf_col === CB'(3) && buf_row === 2'd0 && ready === 1'b0)) begin
      errors++;
      $display("FAIL row2_read: re=%b we=%b col=%0d row=%0d rdy=%b required 1/0/3/0/0", re, we, buf_col, buf_row, ready);
    end
    checks++;
    if (m_col !== CB'(3) || m_row !== RB'(0)) begin
      errors++;
      $display("FAIL row2_matrix: mcol=%0d mrow=%0d required 3/0", m_col, m_row);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || re !== 1'b0 || we !== 1'b0) begin
      errors++;
      $display("FAIL row2_ready: rdy=%b re=%b we=%b required 1/0/0", ready, re, we);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || m_col !== CB'(3) || m_row !== RB'(0)) begin
      errors++;
      $display("FAIL row2_hold: rdy=%b mcol=%0d mrow=%0d required 0/3/0", ready, m_col, m_row);
    end
    #1;
  endtask

  task automatic test_frame_wrap();
    int w0, r0, y0;
    for (int r = 2; r < ROWS; r++)
      for (int c = (r == 2) ? 6 : 0; c < COLS; c++)
        if (!(r == ROWS - 1 && c == COLS - 1)) send(1'b1, PD'(c));
    @(negedge clk);
    stb = 1'b1; dv = 1'b1; pix = 4'h7;
    @(negedge clk);
    stb = 1'b0; dv = 1'b0;
    checks++;
    if (!(we === 1'b1 && buf_col === CB'(639) && buf_row === 2'd2 && buf_pixel === 4'h7)) begin
      errors++;
      $display("FAIL wrap_last_write: we=%b col=%0d row=%0d pix=%0h required 1/639/2/7", we, buf_col, buf_row, buf_pixel);
    end
    @(negedge clk);
    checks++;
    if (!(re === 1'b1 && buf_col === CB'(637) && buf_row === 2'd0 && m_col === CB'(637) && m_row === RB'(3))) begin
      errors++;
      $display("FAIL wrap_last_read: re=%b col=%0d row=%0d mcol=%0d mrow=%0d required 1/637/0/637/3", re, buf_col, buf_row, m_col, m_row);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL wrap_last_ready: rdy=%b required 1", ready);
    end
    #1;
    w0 = wr_cnt; r0 = rd_cnt; y0 = rdy_cnt;
    send(1'b1, 4'h2);
    checks++;
    if (last_wcol !== '0 || last_wrow !== 2'd0 || wr_cnt !== w0 + 1) begin
      errors++;
      $display("FAIL wrap_first: col=%0d row=%0d writes=%0d required 0/0/1", last_wcol, last_wrow, wr_cnt - w0);
    end
    for (int i = 1; i < 2 * COLS; i++) send(1'b1, PD'(i));
    checks++;
    if (rd_cnt !== r0 || rdy_cnt !== y0 || last_wrow !== 2'd1 || last_wcol !== CB'(639)) begin
      errors++;
      $display("FAIL wrap_no_reads: reads=%0d ready=%0d row=%0d col=%0d required 0/0/1/639", rd_cnt - r0, rdy_cnt - y0, last_wrow, last_wcol);
    end
  endtask

  task automatic test_reset_mid();
    int w0, r0, y0;
    send(1'b1, 4'h0);
    send(1'b1, 4'h1);
    @(negedge clk);
    stb = 1'b1; dv = 1'b1; pix = 4'h4;
    @(negedge clk);
    stb = 1'b0; dv = 1'b0;
    checks++;
    if (!(we === 1'b1 && buf_col === CB'(2) && buf_row === 2'd2)) begin
      errors++;
      $display("FAIL mid_write: we=%b col=%0d row=%0d required 1/2/2", we, buf_col, buf_row);
    end
    @(negedge clk);
    checks++;
    if (!(re === 1'b1 && buf_col === '0 && buf_row === 2'd0 && m_col === '0 && m_row === '0)) begin
      errors++;
      $display("FAIL mid_read: re=%b col=%0d row=%0d mcol=%0d mrow=%0d required 1/0/0/0/0", re, buf_col, buf_row, m_col, m_row);
    end
    rst = 1'b1;
    #1;
    y0 = rdy_cnt;
    @(negedge clk);
    checks++;
    if ({we, re, ready, overrun, buf_col, buf_row, buf_pixel, m_col, m_row} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: we=%b re=%b rdy=%b ovr=%b col=%0d row=%0d mcol=%0d mrow=%0d required all 0",
               we, re, ready, overrun, buf_col, buf_row, m_col, m_row);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (rdy_cnt !== y0) begin
      errors++;
      $display("FAIL mid_no_ready: ready pulses=%0d required 0", rdy_cnt - y0);
    end
    w0 = wr_cnt; r0 = rd_cnt;
    send(1'b1, 4'hE);
    checks++;
    if (wr_cnt !== w0 + 1 || last_wcol !== '0 || last_wrow !== 2'd0 || rd_cnt !== r0) begin
      errors++;
      $display("FAIL mid_next_write: writes=%0d col=%0d row=%0d reads=%0d required 1/0/0/0", wr_cnt - w0, last_wcol, last_wrow, rd_cnt - r0);
    end
  endtask

  initial begin
    test_reset();
    test_qualification();
    test_overrun();
    test_first_row();
    test_row2();
    test_frame_wrap();
    test_reset_mid();
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL we_re_exclusive: overlap cycles=%0d required 0", both_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
